uart_cmd_assembler: RTL and testbench
=====================================

UART_CMD_ASSEMBLER -- requirements
Module: uart_cmd_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'hFFFF, giving the max clk cycles allowed between high and low command bytes.
REQ-002 SHALL have port clk, input, 1, system clock (100MHz), rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_rdy, input, 1, UART receiver byte-available flag.
REQ-005 SHALL have port rx_data, input, 8, received byte.
REQ-006 SHALL have port clr_rx_rdy, output, 1, one-cycle acknowledge that consumes rx_data.
REQ-007 SHALL have port cmd, output, 16, assembled command {high byte, low byte}.
REQ-008 SHALL have port cmd_rdy, output, 1, complete command valid.
REQ-009 SHALL have port clr_cmd_rdy, input, 1, consumer acknowledge of cmd.
REQ-010 SHALL have port send_resp, input, 1, request to transmit resp.
REQ-011 SHALL have port resp, input, 8, response byte from command processor.
REQ-012 SHALL have port trmt, output, 1, one-cycle start strobe to UART transmitter.
REQ-013 SHALL have port tx_data, output, 8, byte to transmit.
REQ-014 SHALL have port tx_done, input, 1, transmitter finished flag.
REQ-015 SHALL have port resp_sent, output, 1, one-cycle pulse when response transmission completes.
REQ-016 SHALL have port frame_err, output, 1, one-cycle pulse on inter-byte timeout.

Function
REQ-017 SHALL implement receive FSM states IDLE and WAIT_LOW.
REQ-018 IDLE, rx_rdy=1: SHALL capture rx_data into cmd[15:8], pulse clr_rx_rdy, clear cmd_rdy, go to WAIT_LOW.
REQ-019 WAIT_LOW, rx_rdy=1: SHALL capture rx_data into cmd[7:0], pulse clr_rx_rdy, set cmd_rdy next cycle, go to IDLE.
REQ-020 The byte-to-cmd_rdy latency SHALL be 1 clk after the cycle rx_rdy is sampled with the low byte.
REQ-021 The WAIT_LOW cycle counter (16-bit) SHALL reset on entry to WAIT_LOW.
REQ-022 WAIT_LOW: when the counter reaches TIMEOUT with no rx_rdy, the block SHALL pulse frame_err, discard the high byte, leave cmd_rdy low, and return to IDLE.
REQ-023 If rx_rdy arrives in the same cycle the counter reaches TIMEOUT, the byte SHALL be accepted and no frame_err raised.
REQ-024 cmd_rdy SHALL be cleared by clr_cmd_rdy or by the first byte of the next command.
REQ-025 If completion and clr_cmd_rdy coincide, cmd_rdy SHALL be set (set wins).
REQ-026 cmd SHALL hold its last value until overwritten byte-wise.
REQ-027 SHALL implement transmit FSM states TX_IDLE and TX_BUSY, independent of the receive FSM.
REQ-028 TX_IDLE, send_resp=1: SHALL latch resp into tx_data, pulse trmt for one cycle, go to TX_BUSY.
REQ-029 TX_BUSY, tx_done=1: SHALL pulse resp_sent for one cycle and return to TX_IDLE.
REQ-030 send_resp in TX_BUSY SHALL be ignored (no queueing).
REQ-031 tx_data SHALL remain stable throughout TX_BUSY.
REQ-032 Receive and transmit SHALL operate concurrently without interaction.

Reset
REQ-033 On rst_n low the block SHALL asynchronously enter IDLE/TX_IDLE with cmd=16'h0000, tx_data=8'h00, counter=0, and cmd_rdy, clr_rx_rdy, trmt, resp_sent, frame_err all 0.
REQ-034 Reset asserted mid-command or mid-transmit SHALL discard partial state; no strobe SHALL be emitted on reset release.

Structure
REQ-035 FSM state enums and the command field positions (opcode cmd[15:14], READ=2'b00, WRITE=2'b01, DUMP=2'b10) SHALL live in shared package la_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the UART rx/tx instances are external.

Verification
REQ-037 Bytes 8'h41 then 8'h2C, 10 cycles apart -> cmd=16'h412C, cmd_rdy high 1 cycle after the 2nd rx_rdy, two clr_rx_rdy pulses.
REQ-038 Byte 8'h80, then none for TIMEOUT cycles (TIMEOUT=16'd50) -> frame_err pulse at cycle 50, cmd_rdy stays 0; next pair 8'h00/8'h05 -> cmd=16'h0005.
REQ-039 clr_cmd_rdy asserted in the same cycle as low-byte completion -> cmd_rdy=1.
REQ-040 send_resp with resp=8'hA5 -> trmt 1 cycle, tx_data=8'hA5; second send_resp with resp=8'h5A before tx_done -> ignored; tx_done -> resp_sent pulse, tx_data still 8'hA5.
REQ-041 rst_n low while in WAIT_LOW and TX_BUSY -> all outputs at reset values; after release, a full pair 8'h12/8'h34 -> cmd=16'h1234.
REQ-042 rx pair 8'hC0/8'h00 concurrent with a response transmission of 8'hFF -> both complete correctly, cmd=16'hC000, resp_sent pulsed.

Source files
------------

// File: rtl/la_pkg.sv
// Shared definitions for the UART command assembler.
//   - Receive FSM states (IDLE, WAIT_LOW) and transmit FSM states (TX_IDLE, TX_BUSY).
//   - Bit positions of the command opcode field and its encodings.
//   - cmd_opcode(): extracts the opcode field from an assembled 16-bit command.
package la_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  // Opcode occupies the two MSBs of the assembled command.
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 14;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10
  } opcode_e;

  // Plain 2-bit return so the unassigned encoding 2'b11 passes through unchanged.
  function automatic logic [1:0] cmd_opcode(input logic [15:0] c);
    return c[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler
//   Assembles two received UART bytes (high, then low) into a 16-bit command,
//   and independently sends single response bytes to a UART transmitter.
//
// Parameters
//   TIMEOUT     : max clk cycles allowed between the high and low command bytes.
// Ports
//   clk         : system clock, rising edge.
//   rst_n       : asynchronous active-low reset.
//   rx_rdy      : receiver has a byte available.
//   rx_data     : received byte.
//   clr_rx_rdy  : one-cycle acknowledge that consumes rx_data.
//   cmd         : assembled command {high byte, low byte}.
//   cmd_rdy     : complete command valid; cleared by clr_cmd_rdy or the next high byte.
//   clr_cmd_rdy : consumer acknowledge of cmd.
//   send_resp   : request to transmit resp (ignored while a transmission is active).
//   resp        : response byte.
//   trmt        : one-cycle start strobe to the transmitter.
//   tx_data     : byte being transmitted, stable while busy.
//   tx_done     : transmitter finished.
//   resp_sent   : one-cycle pulse when the transmission completes.
//   frame_err   : one-cycle pulse when the low byte does not arrive in time.
module uart_cmd_assembler
  import la_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic        frame_err
);

  rx_state_e   rx_state_q, rx_state_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        clr_rx_rdy_q, clr_rx_rdy_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, trmt_d;
  logic        resp_sent_q, resp_sent_d;
  logic        rx_accept;

  // clr_rx_rdy is registered, so the receiver's flag is still high in the
  // cycle our acknowledge is out; ignore it then to avoid taking a byte twice.
  assign rx_accept = rx_rdy & ~clr_rx_rdy_q;

  // Receive FSM: next state and registered strobes.
  always_comb begin
    rx_state_d   = rx_state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    cmd_rdy_d    = cmd_rdy_q & ~clr_cmd_rdy;
    clr_rx_rdy_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_accept) begin
          cmd_d[15:8]  = rx_data;
          clr_rx_rdy_d = 1'b1;
          cmd_rdy_d    = 1'b0;
          cnt_d        = 16'd0;
          rx_state_d   = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // A byte arriving on the timeout cycle takes priority over the error.
        if (rx_accept) begin
          cmd_d[7:0]   = rx_data;
          clr_rx_rdy_d = 1'b1;
          cmd_rdy_d    = 1'b1;        // set wins over a coincident clr_cmd_rdy
          rx_state_d   = IDLE;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          // Counter would reach TIMEOUT this cycle: abandon the partial command.
          frame_err_d  = 1'b1;
          rx_state_d   = IDLE;
        end else begin
          cnt_d        = cnt_q + 16'd1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // Transmit FSM: fully independent of the receive side.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_data_d  = resp;
          trmt_d     = 1'b1;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          resp_sent_d = 1'b1;
          tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= IDLE;
      tx_state_q   <= TX_IDLE;
      cmd_q        <= 16'h0000;
      cnt_q        <= 16'd0;
      cmd_rdy_q    <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
      frame_err_q  <= 1'b0;
      tx_data_q    <= 8'h00;
      trmt_q       <= 1'b0;
      resp_sent_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      tx_state_q   <= tx_state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      cmd_rdy_q    <= cmd_rdy_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      frame_err_q  <= frame_err_d;
      tx_data_q    <= tx_data_d;
      trmt_q       <= trmt_d;
      resp_sent_q  <= resp_sent_d;
    end
  end

  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign clr_rx_rdy = clr_rx_rdy_q;
  assign frame_err  = frame_err_q;
  assign tx_data    = tx_data_q;
  assign trmt       = trmt_q;
  assign resp_sent  = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler (TIMEOUT = 50).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_cmd_assembler;
  import la_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  int clr_cnt = 0;
  logic r;

  uart_cmd_assembler #(.TIMEOUT(16'd50)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp), .trmt(trmt), .tx_data(tx_data),
    .tx_done(tx_done), .resp_sent(resp_sent), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Count acknowledge pulses midway through each cycle.
  always @(negedge clk) if (clr_rx_rdy === 1'b1) clr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART receiver model: flag goes high with the byte and is cleared at the
  // edge after the acknowledge is seen. rdy0 = cmd_rdy right after sampling.
  task automatic rx_byte(input logic [7:0] b, output logic rdy0);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rdy0 = cmd_rdy;
    check("clr_rx_rdy_pulse", {31'd0, clr_rx_rdy}, 32'd1);
    tick();
    rx_rdy = 1'b0;
    check("clr_rx_rdy_single", {31'd0, clr_rx_rdy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp = 8'h00; tx_done = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check("rst_cmd", {16'd0, cmd}, 32'h0000);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
    check("rst_trmt", {31'd0, trmt}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Pair 41/2C, 10 cycles apart
    clr_cnt = 0;
    rx_byte(8'h41, r);
    check("hi_no_rdy", {31'd0, r}, 32'd0);
    check("hi_cmd", {16'd0, cmd}, 32'h4100);
    repeat (8) tick();
    check("pre_lo_rdy", {31'd0, cmd_rdy}, 32'd0);
    rx_byte(8'h2C, r);
    check("lo_rdy_latency", {31'd0, r}, 32'd1);
    check("cmd_412C", {16'd0, cmd}, 32'h412C);
    check("clr_count", clr_cnt, 32'd2);
    check("opcode_write", {30'd0, cmd_opcode(cmd)}, {30'd0, OP_WRITE});
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    check("clr_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);

    // Timeout: high byte 80, nothing for 50 cycles
    rx_byte(8'h80, r);
    repeat (48) tick();
    check("no_ferr_49", {31'd0, frame_err}, 32'd0);
    tick();
    check("ferr_50", {31'd0, frame_err}, 32'd1);
    check("ferr_no_rdy", {31'd0, cmd_rdy}, 32'd0);
    tick();
    check("ferr_one_cycle", {31'd0, frame_err}, 32'd0);
    rx_byte(8'h00, r);
    check("after_ferr_hi", {31'd0, r}, 32'd0);
    rx_byte(8'h05, r);
    check("after_ferr_lo", {31'd0, r}, 32'd1);
    check("cmd_0005", {16'd0, cmd}, 32'h0005);
    check("opcode_read", {30'd0, cmd_opcode(cmd)}, {30'd0, OP_READ});

    // Low byte sampled on the very cycle the counter reaches TIMEOUT
    rx_byte(8'h9A, r);
    check("hi_clears_rdy", {31'd0, cmd_rdy}, 32'd0);
    repeat (48) tick();
    rx_byte(8'h77, r);
    check("edge_accept", {31'd0, r}, 32'd1);
    check("edge_no_ferr", {31'd0, frame_err}, 32'd0);
    check("cmd_9A77", {16'd0, cmd}, 32'h9A77);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;

    // Completion coincides with clr_cmd_rdy: set wins
    rx_byte(8'hB1, r);
    rx_rdy = 1'b1; rx_data = 8'h02; clr_cmd_rdy = 1'b1;
    tick();
    check("set_wins", {31'd0, cmd_rdy}, 32'd1);
    clr_cmd_rdy = 1'b0;
    tick();
    rx_rdy = 1'b0;
    check("set_wins_hold", {31'd0, cmd_rdy}, 32'd1);
    check("cmd_B102", {16'd0, cmd}, 32'hB102);
    check("opcode_dump", {30'd0, cmd_opcode(cmd)}, {30'd0, OP_DUMP});
    // Next high byte clears cmd_rdy
    rx_byte(8'h3C, r);
    check("next_hi_clears", {31'd0, r}, 32'd0);
    rx_byte(8'h3D, r);
    check("cmd_3C3D", {16'd0, cmd}, 32'h3C3D);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;

    // Transmit A5, ignored 5A, then done
    send_resp = 1'b1; resp = 8'hA5;
    tick();
    send_resp = 1'b0;
    check("trmt_pulse", {31'd0, trmt}, 32'd1);
    check("tx_data_A5", {24'd0, tx_data}, 32'hA5);
    tick();
    check("trmt_one_cycle", {31'd0, trmt}, 32'd0);
    send_resp = 1'b1; resp = 8'h5A;
    tick();
    send_resp = 1'b0;
    check("busy_ignore_trmt", {31'd0, trmt}, 32'd0);
    check("busy_tx_data", {24'd0, tx_data}, 32'hA5);
    tick(); tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("resp_sent", {31'd0, resp_sent}, 32'd1);
    check("tx_data_hold", {24'd0, tx_data}, 32'hA5);
    tick();
    check("resp_sent_one", {31'd0, resp_sent}, 32'd0);

    // Reset while in WAIT_LOW and TX_BUSY
    rx_byte(8'hEE, r);
    send_resp = 1'b1; resp = 8'h3C;
    tick();
    send_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_cmd", {16'd0, cmd}, 32'h0000);
    check("arst_tx_data", {24'd0, tx_data}, 32'h00);
    check("arst_trmt", {31'd0, trmt}, 32'd0);
    check("arst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_trmt", {31'd0, trmt}, 32'd0);
    check("rel_clr", {31'd0, clr_rx_rdy}, 32'd0);
    check("rel_resp_sent", {31'd0, resp_sent}, 32'd0);
    check("rel_frame_err", {31'd0, frame_err}, 32'd0);
    rx_byte(8'h12, r);
    check("rel_hi_no_rdy", {31'd0, r}, 32'd0);
    rx_byte(8'h34, r);
    check("rel_lo_rdy", {31'd0, r}, 32'd1);
    check("cmd_1234", {16'd0, cmd}, 32'h1234);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;

    // Concurrent rx pair C0/00 and transmit FF
    send_resp = 1'b1; resp = 8'hFF; rx_rdy = 1'b1; rx_data = 8'hC0;
    tick();
    send_resp = 1'b0;
    check("conc_trmt", {31'd0, trmt}, 32'd1);
    check("conc_tx_data", {24'd0, tx_data}, 32'hFF);
    check("conc_clr", {31'd0, clr_rx_rdy}, 32'd1);
    tick();
    rx_rdy = 1'b1; rx_data = 8'h00; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("conc_resp_sent", {31'd0, resp_sent}, 32'd1);
    check("conc_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("cmd_C000", {16'd0, cmd}, 32'hC000);
    tick();
    rx_rdy = 1'b0;
    check("conc_resp_one", {31'd0, resp_sent}, 32'd0);
    check("conc_rdy_hold", {31'd0, cmd_rdy}, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
